// File: rtl/bus_arb_pkg.sv
// Shared helpers for the bus host arbiter: host index sizing and round-robin pointer advance.
package bus_arb_pkg;

  localparam int unsigned MaxNrHosts = 8;

  // Width of a host index; a single host still needs one bit to hold index 0.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/id_fifo.sv
// Synchronous FIFO of issuer IDs; one entry per accepted-but-unanswered bus transaction.
module id_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW:0]    cnt;
  logic [Width-1:0] mem [Depth];

  // Power-of-two depth lets the pointers wrap on overflow; a depth of one pins them at zero.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (Depth == 1) return '0;
    return p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_i) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_i)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_i, pop_i})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= wdata_i;
  end

  assign rdata_o = mem[rd_ptr];
  assign full_o  = (cnt == (PtrW + 1)'(Depth));
  assign empty_o = (cnt == '0);

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one bus host port among NrHosts req/gnt/rvalid requesters.
module bus_host_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NrHosts-1:0]                   host_req_i,
  output logic [NrHosts-1:0]                   host_gnt_o,
  input  logic [NrHosts-1:0][AddrWidth-1:0]    host_addr_i,
  input  logic [NrHosts-1:0]                   host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]  host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]    host_wdata_i,
  output logic [NrHosts-1:0]                   host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]    host_rdata_o,
  output logic [NrHosts-1:0]                   host_err_o,
  output logic                                 bus_req_o,
  input  logic                                 bus_gnt_i,
  output logic [AddrWidth-1:0]                 bus_addr_o,
  output logic                                 bus_we_o,
  output logic [DataWidth/8-1:0]               bus_be_o,
  output logic [DataWidth-1:0]                 bus_wdata_o,
  input  logic                                 bus_rvalid_i,
  input  logic [DataWidth-1:0]                 bus_rdata_i,
  input  logic                                 bus_err_i,
  output logic                                 unexp_rsp_o
);

  localparam int unsigned IdxW = idx_width(NrHosts);
  typedef logic [IdxW-1:0] host_idx_t;

  host_idx_t   rr_ptr;
  host_idx_t   sel;
  host_idx_t   head;
  logic        sel_vld;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  int unsigned cand;

  // Full is registered occupancy, so a same-cycle pop never opens a grant (no rvalid->gnt path).
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    cand    = 0;
    if (!rst_i && !full) begin
      for (int unsigned i = 0; i < NrHosts; i++) begin
        cand = 32'(rr_ptr) + i;
        if (cand >= NrHosts) cand = cand - NrHosts;
        if (!sel_vld && host_req_i[host_idx_t'(cand)]) begin
          sel_vld = 1'b1;
          sel     = host_idx_t'(cand);
        end
      end
    end
  end

  assign push = sel_vld & bus_gnt_i;
  assign pop  = bus_rvalid_i & ~empty & ~rst_i;

  always_comb begin
    bus_req_o   = sel_vld;
    bus_addr_o  = sel_vld ? host_addr_i[sel]  : '0;
    bus_we_o    = sel_vld ? host_we_i[sel]    : 1'b0;
    bus_be_o    = sel_vld ? host_be_i[sel]    : '0;
    bus_wdata_o = sel_vld ? host_wdata_i[sel] : '0;
  end

  always_comb begin
    host_gnt_o          = '0;
    host_gnt_o[sel]     = push;
    host_rvalid_o       = '0;
    host_rvalid_o[head] = pop;
    host_err_o          = '0;
    host_err_o[head]    = pop & bus_err_i;
    host_rdata_o        = rst_i ? '0 : {NrHosts{bus_rdata_i}};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      unexp_rsp_o <= 1'b0;
    end else begin
      if (push) rr_ptr <= host_idx_t'(rr_next(32'(sel), NrHosts));
      if (bus_rvalid_i && empty) unexp_rsp_o <= 1'b1;
    end
  end

  id_fifo #(
    .Width (IdxW),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (sel),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(host_gnt_o));

  for (genvar g = 0; g < NrHosts; g++) begin : g_req_stable
    a_fields_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (host_req_i[g] && !host_gnt_o[g]) ##1 host_req_i[g] |->
        $stable(host_addr_i[g]) && $stable(host_we_i[g]) &&
        $stable(host_be_i[g]) && $stable(host_wdata_i[g]));
  end

endmodule
